fetch_sequencer: RTL and testbench

Program-counter and fetch controller for the 9-bit core. Drives the 7-bit instruction ROM address, executes the control-flow opcodes (BR/BRZ through an 8-entry branch-target LUT) and detects halt. Provides the Start/Done handshake between the testbench or host and the datapath. Sits between the host handshake, the instruction ROM output and the ALU zero flag.

---
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch controller for the 9-bit core.
// It runs the IDLE/RUN/DONE handshake, executes BR/BRZ through an
// 8-entry branch-target LUT, and detects halt and end of program.
// Optional feature macro: FETCH_SEQ_CYCLE_COUNT_EN enables the saturating
// RUN-cycle counter on CycleCount. When it is not defined, CycleCount is 0.
module fetch_sequencer #(
  parameter int ADDR_W   = 7,
  parameter int MAX_ADDR = 127
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [8:0]        Instr,
  input  logic              Zero,
  input  logic              Stall,
  input  logic              LutWe,
  input  logic [2:0]        LutIdx,
  input  logic [ADDR_W-1:0] LutData,
  output logic [ADDR_W-1:0] InstAddress,
  output logic              Busy,
  output logic              Done,
  output logic [15:0]       CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0]        OP_BR    = 3'b110;
  localparam logic [2:0]        OP_BRZ   = 3'b111;
  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(MAX_ADDR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // Branch-target table. It is deliberately not reset, so targets survive
  // a Reset and persist between runs.
  logic [ADDR_W-1:0] lut_q [8];

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] branch_target;
  logic              branch_taken;
  logic              unused_instr_bits;

  assign opcode            = Instr[8:6];
  assign branch_target     = lut_q[Instr[2:0]];
  assign branch_taken      = (opcode == OP_BR) || ((opcode == OP_BRZ) && Zero);
  assign unused_instr_bits = ^Instr[5:3];

  // The LUT is written only from IDLE. Reset blocks the write on the same edge.
  always_ff @(posedge Clk) begin
    if (!Reset && LutWe && (state_q == S_IDLE)) begin
      lut_q[LutIdx] <= LutData;
    end
  end

  // State and PC registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state and next-PC. A stall freezes the whole decision, so a
  // stalled BRZ looks at Zero again on the cycle it finally proceeds.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (Start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!Stall) begin
          if (branch_taken) begin
            // A branch to itself is the halt idiom. The PC stays frozen on it.
            if (branch_target == pc_q) begin
              state_d = S_DONE;
            end else begin
              pc_d = branch_target;
            end
          end else if (pc_q == LAST_PC) begin
            // End of program. There is no wrap to address 0.
            state_d = S_DONE;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        if (!Start) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  assign InstAddress = pc_q;
  assign Busy        = (state_q == S_RUN);
  assign Done        = (state_q == S_DONE);

`ifdef FETCH_SEQ_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;

  // Count every RUN cycle, stalls included. The count saturates and is held
  // until the next Start.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if ((state_q == S_IDLE) && Start) begin
      cycle_cnt_d = '0;
    end else if ((state_q == S_RUN) && (cycle_cnt_q != 16'hFFFF)) begin
      cycle_cnt_d = cycle_cnt_q + 16'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign CycleCount = cycle_cnt_q;
`else
  assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer. A ROM array inside the bench feeds
// Instr combinationally from InstAddress.
module tb_fetch_sequencer;

`ifdef FETCH_SEQ_CYCLE_COUNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  localparam logic [8:0] NOP = 9'b000_000_000;

  logic        Clk = 1'b0;
  logic        Reset, Start, Zero, Stall, LutWe;
  logic [8:0]  Instr;
  logic [2:0]  LutIdx;
  logic [6:0]  LutData;
  logic [6:0]  InstAddress;
  logic        Busy, Done;
  logic [15:0] CycleCount;

  logic [8:0]  rom [128];

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.ADDR_W(7), .MAX_ADDR(127)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Instr       (Instr),
    .Zero        (Zero),
    .Stall       (Stall),
    .LutWe       (LutWe),
    .LutIdx      (LutIdx),
    .LutData     (LutData),
    .InstAddress (InstAddress),
    .Busy        (Busy),
    .Done        (Done),
    .CycleCount  (CycleCount)
  );

  always #5 Clk = ~Clk;

  assign Instr = rom[InstAddress];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic lut_wr(input logic [2:0] idx, input logic [6:0] data);
    LutWe = 1'b1; LutIdx = idx; LutData = data;
    step(1);
    LutWe = 1'b0;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 128; i++) rom[i] = NOP;
  endtask

  // Pulse Start for one edge and leave the DUT in RUN at PC=0.
  task automatic start_run();
    Start = 1'b1;
    step(1);
    Start = 1'b0;
    chk("start_busy", 32'(Busy), 1);
    chk("start_pc", 32'(InstAddress), 0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Zero = 1'b0; Stall = 1'b0;
    LutWe = 1'b0; LutIdx = '0; LutData = '0;
    rom_clear();
    step(2);
    chk("rst_pc", 32'(InstAddress), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_cc", 32'(CycleCount), 0);
    Reset = 1'b0;
    step(1);
    chk("idle_busy", 32'(Busy), 0);

    lut_wr(3'd2, 7'd25);
    lut_wr(3'd3, 7'd40);
    lut_wr(3'd6, 7'd39);
    $display("lut written: [2]=25 [3]=40 [6]=39");

    // Straight-line program that runs to MAX_ADDR, with Start held through DONE.
    Start = 1'b1;
    step(1);
    chk("sl_busy", 32'(Busy), 1);
    chk("sl_pc0", 32'(InstAddress), 0);
    for (int i = 1; i < 128; i++) begin
      step(1);
      chk("sl_pc", 32'(InstAddress), 32'(i));
    end
    step(1);
    chk("sl_done", 32'(Done), 1);
    chk("sl_busy_end", 32'(Busy), 0);
    chk("sl_pc_end", 32'(InstAddress), 127);
    chk("sl_cc", 32'(CycleCount), CC_EN ? 128 : 0);
    step(1);
    chk("sl_done_hold", 32'(Done), 1);
    chk("sl_pc_hold", 32'(InstAddress), 127);
    Start = 1'b0;
    step(1);
    chk("sl_idle_done", 32'(Done), 0);
    chk("sl_idle_pc", 32'(InstAddress), 0);
    chk("sl_cc_hold", 32'(CycleCount), CC_EN ? 128 : 0);
    $display("run straight-line: pc 0..127 then done");

    // Halt: BRZ 2 at PC 25 with LUT[2]=25 and Zero=1.
    rom_clear();
    rom[25] = 9'b111_000_010;
    Zero = 1'b1;
    start_run();
    step(25);
    chk("halt_pc25", 32'(InstAddress), 25);
    step(1);
    chk("halt_done", 32'(Done), 1);
    chk("halt_busy", 32'(Busy), 0);
    chk("halt_pc", 32'(InstAddress), 25);
    chk("halt_cc", 32'(CycleCount), CC_EN ? 26 : 0);
    step(1);
    chk("halt_idle", 32'(Done), 0);
    $display("run halt: BRZ 2 at pc 25");

    // BRZ 3 at PC 33: not taken with Zero=0, then taken with Zero=1. BR 6 halts at 39.
    rom_clear();
    rom[33] = 9'b111_000_011;
    rom[34] = 9'b110_000_110;
    rom[39] = 9'b110_000_110;
    rom[40] = 9'b110_000_110;
    Zero = 1'b0;
    start_run();
    step(33);
    chk("brz0_pc33", 32'(InstAddress), 33);
    step(1);
    chk("brz0_next", 32'(InstAddress), 34);
    step(1);
    chk("br_taken", 32'(InstAddress), 39);
    step(1);
    chk("br_halt", 32'(Done), 1);
    step(1);
    $display("run brz not taken: 33 -> 34 -> 39 halt");
    Zero = 1'b1;
    start_run();
    step(33);
    step(1);
    chk("brz1_next", 32'(InstAddress), 40);
    step(1);
    chk("brz1_br", 32'(InstAddress), 39);
    step(1);
    chk("brz1_halt", 32'(Done), 1);
    step(1);
    $display("run brz taken: 33 -> 40 -> 39 halt");

    // Stall for 3 cycles at PC 10, then run to the BR 2 halt at PC 25.
    rom_clear();
    rom[25] = 9'b110_000_010;
    Zero = 1'b0;
    start_run();
    step(10);
    chk("stall_pc10", 32'(InstAddress), 10);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_hold", 32'(InstAddress), 10);
    end
    Stall = 1'b0;
    step(1);
    chk("stall_release", 32'(InstAddress), 11);
    step(14);
    chk("stall_pc25", 32'(InstAddress), 25);
    step(1);
    chk("stall_done", 32'(Done), 1);
    chk("stall_cc", 32'(CycleCount), CC_EN ? 29 : 0);
    step(1);
    $display("run stall: 3 stall cycles at pc 10");

    // LutWe during RUN is ignored, then Reset at PC 50 returns to IDLE.
    rom_clear();
    start_run();
    step(5);
    LutWe = 1'b1; LutIdx = 3'd2; LutData = 7'd99;
    step(1);
    LutWe = 1'b0;
    step(44);
    chk("rr_pc50", 32'(InstAddress), 50);
    Reset = 1'b1;
    step(1);
    chk("rr_pc", 32'(InstAddress), 0);
    chk("rr_busy", 32'(Busy), 0);
    chk("rr_done", 32'(Done), 0);
    chk("rr_cc", 32'(CycleCount), 0);
    Reset = 1'b0;
    rom[25] = 9'b111_000_010;
    Zero = 1'b1;
    start_run();
    step(25);
    step(1);
    chk("rr_lut_kept", 32'(Done), 1);
    chk("rr_lut_pc", 32'(InstAddress), 25);
    step(1);
    $display("run reset mid-run: lut preserved, halt at 25");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
